// File: rtl/xm_tx_frame_arbiter.sv
// Frame-level round-robin arbiter sharing one xm_top tx lane between sources.
// Responses are routed back to the sending source via an in-order ID FIFO.
module xm_tx_frame_arbiter #(
    parameter int NUM_SRC   = 2,
    parameter int SRC_IDX_W = 1,
    parameter int RSP_DEPTH = 4
) (
    input  logic                   tx_user_clk_i,
    input  logic                   tx_user_rst_i,
    input  logic [NUM_SRC*32-1:0]  s_tx_data_i,
    input  logic [NUM_SRC*2-1:0]   s_tx_vldb_i,
    input  logic [NUM_SRC-1:0]     s_tx_valid_i,
    output logic [NUM_SRC-1:0]     s_tx_ready_o,
    input  logic [NUM_SRC-1:0]     s_tx_last_i,
    input  logic [NUM_SRC-1:0]     s_tx_user_i,
    output logic [NUM_SRC-1:0]     s_tx_status_o,
    output logic [NUM_SRC-1:0]     s_tx_rsp_valid_o,
    output logic [31:0]            m_tx_data_o,
    output logic [1:0]             m_tx_vldb_o,
    output logic                   m_tx_valid_o,
    input  logic                   m_tx_ready_i,
    output logic                   m_tx_last_o,
    output logic                   m_tx_user_o,
    input  logic                   m_tx_status_i,
    input  logic                   m_tx_rsp_valid_i,
    output logic [SRC_IDX_W-1:0]   grant_o,
    output logic                   busy_o,
    output logic                   rsp_err_o
);

    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RSP_DEPTH);
    localparam logic [SRC_IDX_W-1:0] LAST_SRC = SRC_IDX_W'(NUM_SRC - 1);
    localparam logic [SRC_IDX_W:0] NSRC_EXT = (SRC_IDX_W + 1)'(NUM_SRC);

    typedef enum logic {
        IDLE,
        XFER
    } state_t;

    state_t                 state;
    logic [SRC_IDX_W-1:0]   grant_q;
    logic                   busy_q;
    logic                   err_q;

    logic [SRC_IDX_W-1:0]   id_mem [RSP_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;

    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   any_req;
    logic                   in_xfer;
    logic                   sel_valid;
    logic                   beat_acc;
    logic                   push;
    logic                   pop;
    logic [SRC_IDX_W-1:0]   head_id;
    logic [SRC_IDX_W-1:0]   winner;
    logic                   found;
    logic [SRC_IDX_W:0]     scan_sum;
    logic [SRC_IDX_W-1:0]   scan_idx;

    assign fifo_full  = (count == FULL_CNT);
    assign fifo_empty = (count == '0);
    assign any_req    = |s_tx_valid_i;
    assign in_xfer    = (state == XFER) && !tx_user_rst_i;
    assign head_id    = id_mem[rd_ptr];

    // Combinational mux from the granted source onto the shared lane.
    always_comb begin
        m_tx_data_o = '0;
        m_tx_vldb_o = '0;
        m_tx_last_o = 1'b0;
        m_tx_user_o = 1'b0;
        sel_valid   = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (grant_q == SRC_IDX_W'(k)) begin
                m_tx_data_o = s_tx_data_i[k*32 +: 32];
                m_tx_vldb_o = s_tx_vldb_i[k*2 +: 2];
                m_tx_last_o = s_tx_last_i[k];
                m_tx_user_o = s_tx_user_i[k];
                sel_valid   = s_tx_valid_i[k];
            end
        end
    end

    assign m_tx_valid_o = in_xfer && sel_valid;
    assign beat_acc     = m_tx_valid_o && m_tx_ready_i;
    assign push         = beat_acc && m_tx_last_o;
    assign pop          = m_tx_rsp_valid_i && !fifo_empty && !tx_user_rst_i;

    always_comb begin
        s_tx_ready_o     = '0;
        s_tx_rsp_valid_o = '0;
        s_tx_status_o    = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            s_tx_ready_o[k] = in_xfer && m_tx_ready_i &&
                              (grant_q == SRC_IDX_W'(k));
            s_tx_rsp_valid_o[k] = pop && (head_id == SRC_IDX_W'(k));
            s_tx_status_o[k] = s_tx_rsp_valid_o[k] && m_tx_status_i;
        end
    end

    // Scan grant+1, grant+2, ... modulo NUM_SRC; first requester wins.
    always_comb begin
        winner   = grant_q;
        found    = 1'b0;
        scan_sum = '0;
        scan_idx = '0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            scan_sum = {1'b0, grant_q} + (SRC_IDX_W + 1)'(i);
            if (scan_sum >= NSRC_EXT) begin
                scan_sum = scan_sum - NSRC_EXT;
            end
            scan_idx = scan_sum[SRC_IDX_W-1:0];
            if (!found && s_tx_valid_i[scan_idx]) begin
                found  = 1'b1;
                winner = scan_idx;
            end
        end
    end

    always_ff @(posedge tx_user_clk_i) begin
        if (tx_user_rst_i) begin
            state   <= IDLE;
            grant_q <= LAST_SRC;
            busy_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req && !fifo_full) begin
                        grant_q <= winner;
                        state   <= XFER;
                        busy_q  <= 1'b1;
                    end
                end
                XFER: begin
                    if (push) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge tx_user_clk_i) begin
        if (push) begin
            id_mem[wr_ptr] <= grant_q;
        end
    end

    always_ff @(posedge tx_user_clk_i) begin
        if (tx_user_rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err_q  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A response with nothing outstanding is dropped and latched.
            if (m_tx_rsp_valid_i && fifo_empty) begin
                err_q <= 1'b1;
            end
        end
    end

    assign grant_o   = grant_q;
    assign busy_o    = busy_q;
    assign rsp_err_o = err_q;

endmodule

// File: tb/tb_xm_tx_frame_arbiter.sv
// Randomized bench for xm_tx_frame_arbiter against a queue-based frame model.
// Sources emit tagged frames; the model predicts lane, ready and response routing.
module tb_xm_tx_frame_arbiter;

    localparam int N = 2;
    localparam int W = 1;
    localparam int D = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N*32-1:0]   s_data = '0;
    logic [N*2-1:0]    s_vldb = '0;
    logic [N-1:0]      s_valid = '0;
    logic [N-1:0]      s_ready;
    logic [N-1:0]      s_last = '0;
    logic [N-1:0]      s_user = '0;
    logic [N-1:0]      s_status;
    logic [N-1:0]      s_rsp;
    logic [31:0]       m_data;
    logic [1:0]        m_vldb;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic              m_last;
    logic              m_user;
    logic              m_status = 1'b0;
    logic              m_rsp = 1'b0;
    logic [W-1:0]      grant;
    logic              busy;
    logic              rsp_err;

    always #5 clk = ~clk;

    xm_tx_frame_arbiter #(
        .NUM_SRC   (N),
        .SRC_IDX_W (W),
        .RSP_DEPTH (D)
    ) dut (
        .tx_user_clk_i    (clk),
        .tx_user_rst_i    (rst),
        .s_tx_data_i      (s_data),
        .s_tx_vldb_i      (s_vldb),
        .s_tx_valid_i     (s_valid),
        .s_tx_ready_o     (s_ready),
        .s_tx_last_i      (s_last),
        .s_tx_user_i      (s_user),
        .s_tx_status_o    (s_status),
        .s_tx_rsp_valid_o (s_rsp),
        .m_tx_data_o      (m_data),
        .m_tx_vldb_o      (m_vldb),
        .m_tx_valid_o     (m_valid),
        .m_tx_ready_i     (m_ready),
        .m_tx_last_o      (m_last),
        .m_tx_user_o      (m_user),
        .m_tx_status_i    (m_status),
        .m_tx_rsp_valid_i (m_rsp),
        .grant_o          (grant),
        .busy_o           (busy),
        .rsp_err_o        (rsp_err)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Model: owner of the lane, last grant, outstanding frame IDs.
    int st = 0;
    int gnt = N - 1;
    int q[$];
    bit err = 1'b0;

    // Source generators and stimulus knobs.
    int cnt[N];
    int len[N];
    int fr[N];
    int p_val = 0, p_rdy = 100, p_rsp = 0, p_rst = 0;
    int flen = 0;
    int vmask = 0;

    function automatic int new_len();
        return (flen != 0) ? flen : int'($urandom_range(1, 4));
    endfunction

    task automatic gen_reset();
        for (int k = 0; k < N; k++) begin
            cnt[k] = 0;
            fr[k]  = 0;
            len[k] = new_len();
        end
    endtask

    task automatic cycle();
        logic [N-1:0] ev_rdy, ev_rsp, ev_st;
        logic         ev_valid;
        bit           acc, push;
        int           c;
        @(negedge clk);
        rst = ($urandom_range(999) < p_rst);
        for (int k = 0; k < N; k++) begin
            s_valid[k] = vmask[k] && ($urandom_range(99) < p_val);
            s_data[k*32 +: 32] = {8'(k), 8'(fr[k]), 16'(cnt[k])};
            s_last[k] = (cnt[k] == len[k] - 1);
            s_vldb[k*2 +: 2] = 2'($urandom);
            s_user[k] = 1'($urandom);
        end
        m_ready  = ($urandom_range(99) < p_rdy);
        m_rsp    = ($urandom_range(99) < p_rsp);
        m_status = 1'($urandom);
        #1;
        ev_valid = !rst && st == 1 && s_valid[gnt];
        ev_rdy = '0;
        ev_rsp = '0;
        ev_st  = '0;
        if (!rst && st == 1 && m_ready) ev_rdy[gnt] = 1'b1;
        if (!rst && m_rsp && q.size() > 0) begin
            ev_rsp[q[0]] = 1'b1;
            ev_st[q[0]]  = m_status;
        end
        chk("m_valid", 32'(m_valid), 32'(ev_valid));
        chk("s_ready", 32'(s_ready), 32'(ev_rdy));
        chk("s_rsp", 32'(s_rsp), 32'(ev_rsp));
        chk("s_status", 32'(s_status), 32'(ev_st));
        chk("grant", 32'(grant), 32'(gnt));
        chk("busy", 32'(busy), 32'(st));
        chk("rsp_err", 32'(rsp_err), 32'(err));
        if (ev_valid) begin
            chk("m_data", m_data, s_data[gnt*32 +: 32]);
            chk("m_vldb", 32'(m_vldb), 32'(s_vldb[gnt*2 +: 2]));
            chk("m_last", 32'(m_last), 32'(s_last[gnt]));
            chk("m_user", 32'(m_user), 32'(s_user[gnt]));
        end
        if (rst) begin
            st  = 0;
            gnt = N - 1;
            q.delete();
            err = 1'b0;
            gen_reset();
        end else begin
            acc  = ev_valid && m_ready;
            push = acc && s_last[gnt];
            if (acc) begin
                cnt[gnt]++;
                if (push) begin
                    cnt[gnt] = 0;
                    fr[gnt]++;
                    len[gnt] = new_len();
                end
            end
            if (st == 0) begin
                if (s_valid != '0 && q.size() < D) begin
                    for (int i = 1; i <= N; i++) begin
                        c = (gnt + i) % N;
                        if (s_valid[c]) begin
                            gnt = c;
                            break;
                        end
                    end
                    st = 1;
                end
            end else if (push) begin
                st = 0;
            end
            if (m_rsp) begin
                if (q.size() > 0) void'(q.pop_front());
                else err = 1'b1;
            end
            if (push) q.push_back(gnt);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset(input int n);
        int save;
        save  = p_rst;
        p_rst = 1000;
        run(n);
        p_rst = save;
    endtask

    initial begin
        gen_reset();
        @(posedge clk);
        @(posedge clk);
        do_reset(2);
        // Stray response with nothing outstanding.
        p_val = 0; p_rsp = 100;
        run(1);
        p_rsp = 0;
        run(3);
        do_reset(2);
        // Single source, 3-beat frame, lane always ready.
        vmask = 1; flen = 3; gen_reset(); p_val = 100; p_rdy = 100;
        run(8);
        // Both sources streaming 2-beat frames, responses flowing.
        vmask = 3; flen = 2; p_rsp = 50;
        run(24);
        // Src1 against a stuttering lane.
        vmask = 2; flen = 4; p_rdy = 50; p_rsp = 30;
        run(24);
        // Fill the ID FIFO, then release it with one response.
        do_reset(1);
        vmask = 3; flen = 1; p_rdy = 100; p_rsp = 0;
        run(16);
        p_rsp = 100;
        run(1);
        p_rsp = 0;
        run(4);
        // Reset in the middle of a frame, then a stray response.
        do_reset(1);
        vmask = 1; flen = 4; gen_reset();
        run(3);
        do_reset(1);
        p_val = 0; p_rsp = 100;
        run(1);
        p_rsp = 0;
        run(2);
        // Long random mix including occasional resets.
        vmask = 3; flen = 0; p_val = 70; p_rdy = 70; p_rsp = 30; p_rst = 3;
        run(3000);
        p_rst = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/xm_tx_frame_arbiter.md
Name: xm_tx_frame_arbiter

Overview:
- Shares one lane's tx user interface on xm_top (data/vldb/valid/ready/last/user plus status/rsp_valid) between NUM_SRC frame sources, for example prbs_gen and a register/debug frame injector.
- Arbitration is frame-level round-robin: a grant is held from the first beat through the accepted last beat.
- Each tx_rsp_valid/tx_status response is routed back to the source whose frame it answers, using an in-order ID FIFO.

Parameters:
- NUM_SRC, 2, number of requesting sources (2..8).
- SRC_IDX_W, 1, width of a source index; must satisfy 2^SRC_IDX_W >= NUM_SRC.
- RSP_DEPTH, 4, number of frames awaiting a response; power of two, at least 2.

Ports:
- tx_user_clk_i  in  1  tx user clock from xm_top.
- tx_user_rst_i  in  1  synchronous, active-high reset.
- s_tx_data_i  in  NUM_SRC*32  per-source data; source k uses [k*32 +: 32].
- s_tx_vldb_i  in  NUM_SRC*2  per-source valid-byte code.
- s_tx_valid_i  in  NUM_SRC  per-source beat valid.
- s_tx_ready_o  out  NUM_SRC  per-source beat ready.
- s_tx_last_i  in  NUM_SRC  per-source last beat of frame.
- s_tx_user_i  in  NUM_SRC  per-source user bit.
- s_tx_status_o  out  NUM_SRC  routed frame status.
- s_tx_rsp_valid_o  out  NUM_SRC  routed response strobe.
- m_tx_data_o  out  32  to xm_top tx_data_i.
- m_tx_vldb_o  out  2  to xm_top tx_vldb_i.
- m_tx_valid_o  out  1  to xm_top tx_valid_i.
- m_tx_ready_i  in  1  from xm_top tx_ready_o.
- m_tx_last_o  out  1  to xm_top tx_last_i.
- m_tx_user_o  out  1  to xm_top tx_user_i.
- m_tx_status_i  in  1  from xm_top tx_status_o.
- m_tx_rsp_valid_i  in  1  from xm_top tx_rsp_valid_o.
- grant_o  out  SRC_IDX_W  current or most recent granted source.
- busy_o  out  1  high in XFER state.
- rsp_err_o  out  1  sticky: a response arrived while the ID FIFO was empty.

Behaviour:
- Clocking and reset:
  - Single clock tx_user_clk_i. All state is reset synchronously by tx_user_rst_i.
  - Reset values: state=IDLE, grant_o=NUM_SRC-1 (so source 0 wins first), busy_o=0, rsp_err_o=0, FIFO empty.
  - All s_tx_ready_o, s_tx_rsp_valid_o and s_tx_status_o are 0 during and after reset.
  - m_tx_valid_o=0 during and after reset; m_tx_data/vldb/last/user are don't-care when m_tx_valid_o=0.
- FSM IDLE:
  - Advance only when any s_tx_valid_i=1 AND the FIFO is not full.
  - Winner is the first valid source scanning grant_o+1, grant_o+2, ..., wrapping modulo NUM_SRC.
  - Register the winner into grant_o and go to XFER. No beat passes in IDLE.
  - FIFO full blocks arbitration. Requesters wait, and all ready outputs stay 0.
- FSM XFER:
  - Zero-latency combinational mux. The m_tx_* outputs equal the granted source's inputs.
  - s_tx_ready_o[grant] = m_tx_ready_i; all other ready bits = 0.
  - A beat is accepted when m_tx_valid_o & m_tx_ready_i.
  - On the accepted beat with last=1: push grant_o into the FIFO and return to IDLE.
  - Minimum inter-frame gap is therefore exactly one IDLE cycle.
  - The granted source may deassert valid mid-frame; the grant is held regardless.
- Fairness: with all sources continuously requesting, grants rotate 0,1,...,NUM_SRC-1,0,...
- Response routing:
  - On m_tx_rsp_valid_i=1 with the FIFO non-empty: pop the head ID h, and in the same cycle drive s_tx_rsp_valid_o[h]=1 and s_tx_status_o[h]=m_tx_status_i (combinational).
  - On m_tx_rsp_valid_i=1 with the FIFO empty: drop the response and set rsp_err_o=1 until reset.
  - A push and a pop in the same cycle are both performed; occupancy is unchanged, even when the FIFO is full.
  - A pop of an empty FIFO with a simultaneous push is treated as empty: the response is dropped, rsp_err_o is set, and the push still occurs.
- Counter widths: occupancy counter is clog2(RSP_DEPTH)+1 bits; read/write pointers wrap modulo RSP_DEPTH.
- Reset mid-frame: the frame is abandoned, its ID is not pushed, and the next frame restarts at IDLE.

Test Plan:
- Reset, then src0 sends a 3-beat frame (data 0x11,0x22,0x33, last on beat 3) with m_tx_ready_i=1 -> grant_o=0; m_tx_data shows 0x11,0x22,0x33 starting 1 cycle after valid rises; s_tx_ready_o[1]=0 throughout.
- Both sources continuously send 2-beat frames -> grant order 0,1,0,1; exactly one idle cycle between frames; busy_o pattern 1,1,0 repeating.
- Src1 frame with m_tx_ready_i toggling 1,0,1,0 -> src1 ready mirrors m_tx_ready_i; 4 beats take 8 cycles; no beat duplicated or lost.
- RSP_DEPTH=4: four 1-beat frames with no responses -> fifth request is stalled in IDLE. One m_tx_rsp_valid_i pulse with status=1 -> s_tx_rsp_valid_o/s_tx_status_o fire for the first frame's source; the stalled request is granted next cycle.
- m_tx_rsp_valid_i pulse right after reset -> no s_tx_rsp_valid_o; rsp_err_o=1 and it stays 1 until reset.
- Assert tx_user_rst_i on beat 2 of a 4-beat src0 frame -> next cycle m_tx_valid_o=0 and FIFO empty. A later response pulse sets rsp_err_o.
